// File: rtl/instruction_memory_if.sv
// Fetch-address bus and program-loader byte stream for instruction_memory.
// The slave side is the memory; the master side holds the fetch unit and the loader.
interface instruction_memory_if #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned DATA_W     = 8
);
  logic                  im_abus_valid;
  logic [DEPTH_LOG2-1:0] im_abus_data;
  logic [DATA_W-1:0]     im_data;
  logic                  im_data_valid;
  logic                  ld_start;
  logic                  ld_valid;
  logic [DATA_W-1:0]     ld_data;
  logic                  ld_end;
  logic                  ld_ready;
  logic                  ld_done;
  logic [DEPTH_LOG2:0]   ld_count;

  modport slave (
    input  im_abus_valid, im_abus_data, ld_start, ld_valid, ld_data, ld_end,
    output im_data, im_data_valid, ld_ready, ld_done, ld_count
  );

  modport master (
    output im_abus_valid, im_abus_data, ld_start, ld_valid, ld_data, ld_end,
    input  im_data, im_data_valid, ld_ready, ld_done, ld_count
  );
endinterface

// File: rtl/instruction_memory.sv
// Program store: answers PC fetches with one cycle of latency, and is filled
// sequentially from address 0 through a valid/ready byte-load port.
module instruction_memory #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_memory_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic {RUN, LOAD} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       ld_count_q, ld_count_d;
  logic [DATA_W-1:0]   im_data_q, im_data_d;
  logic                im_data_valid_q, im_data_valid_d;
  logic                ld_ready_q, ld_ready_d;
  logic                ld_done_q, ld_done_d;
  logic                mem_we_c;
  logic [DEPTH_LOG2-1:0] wr_addr_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign wr_addr_c = wr_ptr_q[DEPTH_LOG2-1:0];

  // Next-state and output logic.
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    ld_count_d      = ld_count_q;
    im_data_d       = im_data_q;
    im_data_valid_d = 1'b0;
    ld_ready_d      = ld_ready_q;
    ld_done_d       = 1'b0;
    mem_we_c        = 1'b0;

    case (state_q)
      RUN: begin
        ld_ready_d = 1'b0;
        // A fetch in the same cycle as ld_start is still answered.
        if (bus.im_abus_valid) begin
          im_data_d       = mem[bus.im_abus_data];
          im_data_valid_d = 1'b1;
        end
        if (bus.ld_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          ld_count_d = '0;
          ld_ready_d = 1'b1;
        end
      end
      LOAD: begin
        im_data_d  = '0;
        ld_ready_d = 1'b1;
        if (bus.ld_start) begin
          wr_ptr_d   = '0;
          ld_count_d = '0;
        end else if (bus.ld_valid && ld_ready_q) begin
          mem_we_c   = 1'b1;
          wr_ptr_d   = wr_ptr_q + CW'(1);
          ld_count_d = ld_count_q + CW'(1);
          // Last beat or store full: the pointer never wraps.
          if (bus.ld_end || (wr_ptr_q == CW'(DEPTH - 1))) begin
            state_d    = RUN;
            ld_done_d  = 1'b1;
            ld_ready_d = 1'b0;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RUN;
      wr_ptr_q        <= '0;
      ld_count_q      <= '0;
      im_data_q       <= '0;
      im_data_valid_q <= 1'b0;
      ld_ready_q      <= 1'b0;
      ld_done_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      ld_count_q      <= ld_count_d;
      im_data_q       <= im_data_d;
      im_data_valid_q <= im_data_valid_d;
      ld_ready_q      <= ld_ready_d;
      ld_done_q       <= ld_done_d;
    end
  end

  // Store contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[wr_addr_c] <= bus.ld_data;
    end
  end

  assign bus.im_data       = im_data_q;
  assign bus.im_data_valid = im_data_valid_q;
  assign bus.ld_ready      = ld_ready_q;
  assign bus.ld_done       = ld_done_q;
  assign bus.ld_count      = ld_count_q;

endmodule
